// File: rtl/csmulti_iterative_if.sv
// Operand/product handshake bundle for csmulti_iterative.
// CSMULT_SIGNED_EN adds op_signed, which travels with the operands.
interface csmulti_iterative_if #(parameter int BITSIZE = 8);
  logic                   in_valid;
  logic                   in_ready;
  logic [BITSIZE-1:0]     factor0;
  logic [BITSIZE-1:0]     factor1;
  logic                   out_valid;
  logic                   out_ready;
  logic [2*BITSIZE-1:0]   product;
  logic                   busy;
`ifdef CSMULT_SIGNED_EN
  logic                   op_signed;
`endif

  modport master (
    output in_valid, factor0, factor1, out_ready,
`ifdef CSMULT_SIGNED_EN
    output op_signed,
`endif
    input  in_ready, out_valid, product, busy
  );

  modport slave (
    input  in_valid, factor0, factor1, out_ready,
`ifdef CSMULT_SIGNED_EN
    input  op_signed,
`endif
    output in_ready, out_valid, product, busy
  );
endinterface

// File: rtl/csmulti_iterative.sv
// Iterative carry-save multiplier: STEP rows per cycle into a (sum, carry) pair, one final add.
// CSMULT_SIGNED_EN enables two's-complement operation selected per op by op_signed.
module csmulti_iterative #(
  parameter int BITSIZE = 8,
  parameter int STEP    = 2
) (
  input  logic               clk,
  input  logic               rst,
  csmulti_iterative_if.slave bus
);
  localparam int K  = BITSIZE / STEP;
  localparam int PW = 2 * BITSIZE;
  localparam int CW = (K > 1) ? $clog2(K) : 1;

  if (STEP < 1 || STEP > BITSIZE || (BITSIZE % STEP) != 0) begin : g_bad_step
    $error("csmulti_iterative: STEP must be in 1..BITSIZE and divide BITSIZE");
  end

  typedef enum logic [1:0] {IDLE, RUN, RESOLVE, DONE} state_t;

  state_t              state;
  logic [PW-1:0]       sum_q, carry_q, f0_sh, s_nx, c_nx;
  logic [BITSIZE-1:0]  f1_sh;
  logic [CW-1:0]       cnt;
  logic                sgn_q, in_ready_q, busy_q, out_valid_q, sgn_in;
  logic [PW-1:0]       product_q;
  logic                last;

`ifdef CSMULT_SIGNED_EN
  assign sgn_in = bus.op_signed;
`else
  assign sgn_in = 1'b0;
`endif

  assign last = (cnt == CW'(K - 1));

  // Multiplicand is pre-extended and shifted left each cycle, multiplier shifted right,
  // so row r of this cycle is always f0_sh << r gated by f1_sh[r]. In signed mode the
  // multiplier's sign row is subtracted: inverted here, +1 added at resolve.
  always_comb begin
    logic [PW-1:0] pp, t;
    s_nx = sum_q;
    c_nx = carry_q;
    for (int r = 0; r < STEP; r++) begin
      pp = f1_sh[r] ? (f0_sh << r) : '0;
      if (sgn_q && last && r == STEP - 1) pp = ~pp;
      t    = s_nx ^ c_nx ^ pp;
      c_nx = ((s_nx & c_nx) | (s_nx & pp) | (c_nx & pp)) << 1;
      s_nx = t;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
      product_q   <= '0;
      sum_q       <= '0;
      carry_q     <= '0;
      f0_sh       <= '0;
      f1_sh       <= '0;
      cnt         <= '0;
      sgn_q       <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.in_valid) begin
          f0_sh      <= sgn_in ? {{BITSIZE{bus.factor0[BITSIZE-1]}}, bus.factor0}
                               : {{BITSIZE{1'b0}}, bus.factor0};
          f1_sh      <= bus.factor1;
          sgn_q      <= sgn_in;
          sum_q      <= '0;
          carry_q    <= '0;
          cnt        <= '0;
          in_ready_q <= 1'b0;
          busy_q     <= 1'b1;
          state      <= RUN;
        end
        RUN: begin
          sum_q   <= s_nx;
          carry_q <= c_nx;
          f0_sh   <= f0_sh << STEP;
          f1_sh   <= f1_sh >> STEP;
          cnt     <= cnt + 1'b1;
          if (last) state <= RESOLVE;
        end
        RESOLVE: begin
          product_q   <= sum_q + carry_q + PW'(sgn_q);
          out_valid_q <= 1'b1;
          busy_q      <= 1'b0;
          state       <= DONE;
        end
        DONE: if (bus.out_ready) begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.busy      = busy_q;
  assign bus.out_valid = out_valid_q;
  assign bus.product   = product_q;
endmodule
